// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - sequencer bus: decode inputs and per-cycle strobes
// Optional CPU_SEQ_STEP_EN adds the single-step controls step/step_mode.
interface cpu_seq_ctrl_if #(parameter int OPC_W = 3);
  logic             ena;
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             load_ir;
  logic             inc_pc;
  logic             load_pc;
  logic             load_acc;
  logic             rd;
  logic             wr;
  logic             datactl_ena;
  logic             halt;
`ifdef CPU_SEQ_STEP_EN
  logic             step;
  logic             step_mode;
`endif

  modport master (
    input  ena, opcode, zero,
`ifdef CPU_SEQ_STEP_EN
    input  step, step_mode,
`endif
    output load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt
  );

  modport slave (
    output ena, opcode, zero,
`ifdef CPU_SEQ_STEP_EN
    output step, step_mode,
`endif
    input  load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - 6-cycle fetch/decode/execute sequencer with sticky HALT
// Optional CPU_SEQ_STEP_EN turns encoding 7 into a single-step WAIT state.
module cpu_seq_ctrl #(
  parameter int OPC_W = 3,
  parameter int ST_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  cpu_seq_ctrl_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    S_F0   = 3'd0,
    S_F1   = 3'd1,
    S_D    = 3'd2,
    S_E0   = 3'd3,
    S_E1   = 3'd4,
    S_E2   = 3'd5,
    S_HALT = 3'd6,
    S_X7   = 3'd7
  } state_e;

  localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPC_W-1:0] OP_STO = 3'b110;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             zero_q, zero_d;

  logic s_ir, s_inc, s_lpc, s_lacc, s_rd, s_wr, s_den, s_hlt;
  logic is_alu, is_sto, is_jmp, is_skz, gate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_F0;
      op_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zero_d  = zero_q;
    s_ir    = 1'b0;
    s_inc   = 1'b0;
    s_lpc   = 1'b0;
    s_lacc  = 1'b0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    s_den   = 1'b0;
    s_hlt   = 1'b0;
    is_alu  = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_LDA);
    is_sto  = (op_q == OP_STO);
    is_jmp  = (op_q == OP_JMP);
    is_skz  = (op_q == OP_SKZ);

    case (state_q)
      S_F0: begin
        s_rd = 1'b1; s_ir = 1'b1; s_inc = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        s_rd = 1'b1; s_ir = 1'b1; s_inc = 1'b1;
        state_d = S_D;
      end
      S_D: begin
        op_d    = bus.opcode;
        zero_d  = bus.zero;
        state_d = S_E0;
      end
      S_E0: begin
        if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          s_rd    = is_alu;
          s_den   = is_sto;
          s_lpc   = is_jmp;
          s_inc   = is_skz && zero_q;
          state_d = S_E1;
        end
      end
      S_E1: begin
        s_rd    = is_alu;
        s_lacc  = is_alu;
        s_den   = is_sto;
        s_wr    = is_sto;
        s_lpc   = is_jmp;
        s_inc   = is_skz && zero_q;
        state_d = S_E2;
      end
      S_E2: begin
        // Holding datactl_ena one cycle past wr keeps write data stable at the falling edge.
        s_den = is_sto;
`ifdef CPU_SEQ_STEP_EN
        state_d = bus.step_mode ? S_X7 : S_F0;
`else
        state_d = S_F0;
`endif
      end
      S_HALT: begin
        s_hlt   = 1'b1;
        state_d = S_HALT;
      end
      S_X7: begin
`ifdef CPU_SEQ_STEP_EN
        state_d = (!bus.step_mode || bus.step) ? S_F0 : S_X7;
`else
        state_d = S_F0;
`endif
      end
      default: state_d = S_F0;
    endcase

    if (!bus.ena) begin
      state_d = state_q;
      op_d    = op_q;
      zero_d  = zero_q;
    end
  end

  // Strobes are Moore decodes; only ena and rst may mask them.
  assign gate            = bus.ena && !rst;
  assign bus.load_ir     = gate && s_ir;
  assign bus.inc_pc      = gate && s_inc;
  assign bus.load_pc     = gate && s_lpc;
  assign bus.load_acc    = gate && s_lacc;
  assign bus.rd          = gate && s_rd;
  assign bus.wr          = gate && s_wr;
  assign bus.datactl_ena = gate && s_den;
  assign bus.halt        = gate && s_hlt;

endmodule
